// File: rtl/mem_fill_responder.sv
// Word-addressed memory responder for cache fills: fixed-latency, fully pipelined reads.
// Optional sticky protocol checker enabled by defining MEM_PROTOCOL_CHECK_EN.
module mem_fill_responder #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cache_MemRead,
    input  logic              cache_MemWrite,
    input  logic [ADDR_W-1:0] cache_mem_addr,
    input  logic [DATA_W-1:0] cache_mem_write_data,
    output logic              MemDataValid,
    output logic [DATA_W-1:0] mem_read_data,
    output logic              mem_err
);
    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [DATA_W-1:0] r_mem [MEM_WORDS];
    logic [DATA_W-1:0] r_rd_word;
    logic [LATENCY-1:0] r_vld;
    logic [IDX_W-1:0]  w_idx;
    logic              w_rd_accept;
    logic [DATA_W-1:0] w_out_dat;
    logic              w_unused_addr;

    // Byte address to word index; anything above the array depth simply wraps.
    assign w_idx         = cache_mem_addr[IDX_W:1];
    assign w_rd_accept   = cache_MemRead & ~cache_MemWrite;
    assign w_unused_addr = ^cache_mem_addr;

    // Array is never reset; the read word is captured before any same-edge write lands.
    always_ff @(posedge clk) begin
        if (cache_MemWrite) begin
            r_mem[w_idx] <= cache_mem_write_data;
        end
        if (w_rd_accept) begin
            r_rd_word <= r_mem[w_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_rd_accept;
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    generate
        if (LATENCY == 1) begin : g_lat1
            assign w_out_dat = r_rd_word;
        end else begin : g_latn
            logic [DATA_W-1:0] r_dat [1:LATENCY-1];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 1; i < LATENCY; i++) begin
                        r_dat[i] <= '0;
                    end
                end else begin
                    r_dat[1] <= r_rd_word;
                    for (int i = 2; i < LATENCY; i++) begin
                        r_dat[i] <= r_dat[i-1];
                    end
                end
            end
            assign w_out_dat = r_dat[LATENCY-1];
        end
    endgenerate

    // Stale stage data is masked so idle cycles always present zero.
    assign MemDataValid  = r_vld[LATENCY-1];
    assign mem_read_data = w_out_dat & {DATA_W{r_vld[LATENCY-1]}};

`ifdef MEM_PROTOCOL_CHECK_EN
    logic w_hi_bits;
    logic w_err_now;
    logic r_err;

    generate
        if (ADDR_W - 1 > IDX_W) begin : g_hi
            assign w_hi_bits = |cache_mem_addr[ADDR_W-1:IDX_W+1];
        end else begin : g_nohi
            assign w_hi_bits = 1'b0;
        end
    endgenerate

    assign w_err_now = (cache_MemRead & cache_MemWrite) |
                       ((cache_MemRead | cache_MemWrite) & (cache_mem_addr[0] | w_hi_bits));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_err_now) begin
            r_err <= 1'b1;
        end
    end

    assign mem_err = r_err;
`else
    assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_fill_responder.sv
// Bench for mem_fill_responder: directed test-plan cases plus random traffic,
// checked against a cycle-indexed schedule of expected responses.
module tb_mem_fill_responder;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int WORDS = 1024;
    localparam int LAT   = 4;
`ifdef MEM_PROTOCOL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rd = 1'b0;
    logic          wr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          vld;
    logic [DW-1:0] rdata;
    logic          err;

    always #5 clk = ~clk;

    mem_fill_responder #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_WORDS(WORDS), .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cache_MemRead(rd),
        .cache_MemWrite(wr),
        .cache_mem_addr(addr),
        .cache_mem_write_data(wdata),
        .MemDataValid(vld),
        .mem_read_data(rdata),
        .mem_err(err)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference: plain word array plus the response expected in each future cycle.
    logic [DW-1:0] mdl_mem [WORDS];
    bit            exp_v [int];
    logic [DW-1:0] exp_d [int];
    bit            err_exp = 1'b0;
    bit            err_pend = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int idx;
        rd = r; wr = w; addr = a; wdata = d;
        idx = int'(a >> 1) % WORDS;
        if (w) begin
            mdl_mem[idx] = d;
        end else if (r) begin
            exp_v[cyc + LAT] = 1'b1;
            exp_d[cyc + LAT] = mdl_mem[idx];
        end
        if ((r && w) || ((r || w) && (a[0] || int'(a >> 1) >= WORDS)))
            err_pend = CHK;
    endtask

    task automatic tick();
        bit            ev;
        logic [DW-1:0] ed;
        @(posedge clk);
        #1;
        cyc++;
        if (err_pend) err_exp = 1'b1;
        err_pend = 1'b0;
        ev = exp_v.exists(cyc) ? exp_v[cyc] : 1'b0;
        ed = exp_d.exists(cyc) ? exp_d[cyc] : '0;
        chk("valid", 32'(vld), 32'(ev));
        chk("data", 32'(rdata), 32'(ed));
        chk("err", 32'(err), 32'(err_exp));
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0);
        tick();
    endtask

    task automatic do_reset();
        rd = 1'b0; wr = 1'b0;
        rst = 1'b1;
        #1;
        exp_v.delete(); exp_d.delete();
        err_exp = 1'b0; err_pend = 1'b0;
        chk("rst_valid", 32'(vld), 32'd0);
        chk("rst_data", 32'(rdata), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #2;
        do_reset();

        // Fill the whole array with known random content.
        for (int i = 0; i < WORDS; i++) begin
            drive(1'b0, 1'b1, AW'(i * 2), DW'($urandom));
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, AW'(i * 2), DW'(i + 1));
            tick();
        end

        // Block fill: 8 back-to-back reads stream back in cycles 4..11.
        for (int i = 0; i < 13; i++) begin
            if (i < 8) drive(1'b1, 1'b0, AW'(i * 2), '0);
            else       drive(1'b0, 1'b0, '0, '0);
            tick();
            if (i + 1 >= LAT && i + 1 < LAT + 8) begin
                chk("fill_valid", 32'(vld), 32'd1);
                chk("fill_data", 32'(rdata), 32'(i + 2 - LAT));
            end
        end

        // Read-after-write returns new data; read-before-write returns old.
        drive(1'b0, 1'b1, 16'd16, 16'hBEEF); tick();
        drive(1'b1, 1'b0, 16'd16, '0);       tick();
        drive(1'b1, 1'b0, 16'd16, '0);       tick();
        drive(1'b0, 1'b1, 16'd16, 16'h1111); tick();
        idle();
        chk("raw_new", 32'(rdata), 32'hBEEF);
        idle();
        chk("war_old", 32'(rdata), 32'hBEEF);
        for (int i = 0; i < 4; i++) idle();

        // Gapped requests propagate as gaps.
        drive(1'b1, 1'b0, 16'd0, '0); tick();
        idle();
        drive(1'b1, 1'b0, 16'd2, '0); tick();
        drive(1'b1, 1'b0, 16'd4, '0); tick();
        chk("gap_c4_valid", 32'(vld), 32'd1);
        idle();
        chk("gap_c5_valid", 32'(vld), 32'd0);
        chk("gap_c5_data", 32'(rdata), 32'd0);
        idle();
        chk("gap_c6_data", 32'(rdata), 32'd2);
        idle();
        chk("gap_c7_data", 32'(rdata), 32'd3);
        for (int i = 0; i < 3; i++) idle();

        // Reset mid-burst discards in-flight reads but keeps the array.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, AW'(i * 2), '0);
            tick();
        end
        drive(1'b1, 1'b0, 16'd10, '0);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            idle();
            chk("post_rst_valid", 32'(vld), 32'd0);
        end
        drive(1'b1, 1'b0, 16'd0, '0); tick();
        for (int i = 0; i < 3; i++) idle();
        chk("reread_data", 32'(rdata), 32'd1);
        idle();

        // Simultaneous read and write: write wins, no response.
        drive(1'b1, 1'b1, 16'd4, 16'h1234); tick();
        chk("conflict_err", 32'(err), 32'(CHK));
        for (int i = 0; i < 6; i++) begin
            idle();
            chk("conflict_novalid", 32'(vld), 32'd0);
        end
        drive(1'b1, 1'b0, 16'd4, '0); tick();
        for (int i = 0; i < 3; i++) idle();
        chk("conflict_wrote", 32'(rdata), 32'h1234);
        chk("conflict_err_held", 32'(err), 32'(CHK));
        do_reset();

        // Out-of-range index wraps onto the low bits.
        drive(1'b0, 1'b1, 16'h0802, 16'h0055); tick();
        chk("wrap_err", 32'(err), 32'(CHK));
        drive(1'b1, 1'b0, 16'h0002, '0); tick();
        for (int i = 0; i < 3; i++) idle();
        chk("wrap_data", 32'(rdata), 32'h0055);
        do_reset();

        // Random traffic, mostly legal addresses, occasional resets.
        for (int n = 0; n < 800; n++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 15) == 0) ? AW'($urandom) : AW'($urandom & 32'h7FE);
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                drive(1'($urandom_range(0, 2) != 0), $urandom_range(0, 3) == 0, a, DW'($urandom));
                tick();
            end
        end
        for (int i = 0; i < LAT + 2; i++) idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
